// File: rtl/jk_stim_driver_pkg.sv
// Shared types and the JK excitation table used by the driver and its checker model.
package jk_stim_driver_pkg;

  typedef enum logic [2:0] {
    StInit0   = 3'd0,
    StInitChk = 3'd1,
    StIdle    = 3'd2,
    StDrive   = 3'd3,
    StCheck   = 3'd4
  } jk_state_e;

  // Returns {j, k} that moves a JK flop from state s to state t; fill goes on the don't-care.
  function automatic logic [1:0] jk_excite(input logic s, input logic t, input logic fill);
    return s ? {fill, ~t} : {t, fill};
  endfunction

endpackage

// File: rtl/jk_stim_driver_if.sv
// Target-bit handshake between a pattern source (master) and the stimulus driver (slave).
interface jk_stim_driver_if;
  logic tgt_valid;
  logic tgt_bit;
  logic tgt_ready;

  modport master (output tgt_valid, output tgt_bit, input tgt_ready);
  modport slave  (input tgt_valid, input tgt_bit, output tgt_ready);
endinterface

// File: rtl/jk_excite_comb.sv
// Pure combinational excitation: current tracked q and wanted q -> {j, k}.
module jk_excite_comb
  import jk_stim_driver_pkg::*;
#(
  parameter bit DC_FILL = 1'b0
) (
  input  logic       track,
  input  logic       tgt,
  output logic [1:0] jk
);

  // Table lookup only; registered by the caller.
  always_comb begin
    jk = jk_excite(track, tgt, DC_FILL);
  end

endmodule

// File: rtl/jk_stim_driver.sv
// Drives j/k onto an external JK flop so its q follows a stream of target bits,
// reads q back one cycle later and counts mismatches.
module jk_stim_driver
  import jk_stim_driver_pkg::*;
#(
  parameter int unsigned CNT_W   = 8,
  parameter bit          DC_FILL = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  jk_stim_driver_if.slave  tgt,
  input  logic             clr_err,
  input  logic             jk_q,
  output logic             jk_j,
  output logic             jk_k,
  output logic             init_done,
  output logic             busy,
  output logic             err_flag,
  output logic [CNT_W-1:0] mism_cnt
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  jk_state_e        state_q;
  logic             exp_q, track_q;
  logic             j_q, k_q, ready_q, busy_q, init_done_q, err_q;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_base;
  logic             err_d, mismatch;
  logic [1:0]       exc;

  jk_excite_comb #(
    .DC_FILL (DC_FILL)
  ) u_excite (
    .track (track_q),
    .tgt   (tgt.tgt_bit),
    .jk    (exc)
  );

  // Compare readback; written as if/else so an unknown q falls into the mismatch branch.
  always_comb begin
    mismatch = 1'b0;
    if (state_q == StInitChk) begin
      if (jk_q == 1'b0) mismatch = 1'b0;
      else              mismatch = 1'b1;
    end else if (state_q == StCheck) begin
      if (jk_q == exp_q) mismatch = 1'b0;
      else               mismatch = 1'b1;
    end
  end

  // Saturating counter next state; a mismatch coinciding with clear survives as a count of 1.
  always_comb begin
    cnt_base = clr_err ? '0 : cnt_q;
    cnt_d    = cnt_base;
    if (mismatch && (cnt_base != CntMax)) cnt_d = cnt_base + CNT_W'(1);
    err_d = mismatch | (err_q & ~clr_err);
  end

  // Error counter and sticky flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  // Main FSM with registered outputs; j/k default to hold (0/0).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StInit0;
      j_q         <= 1'b0;
      k_q         <= 1'b1;
      ready_q     <= 1'b0;
      busy_q      <= 1'b1;
      init_done_q <= 1'b0;
      exp_q       <= 1'b0;
      track_q     <= 1'b0;
    end else begin
      j_q <= 1'b0;
      k_q <= 1'b0;
      case (state_q)
        StInit0: state_q <= StInitChk;
        StInitChk: begin
          if (!mismatch) begin
            init_done_q <= 1'b1;
            track_q     <= 1'b0;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= StIdle;
          end else begin
            k_q     <= 1'b1;
            state_q <= StInit0;
          end
        end
        StIdle: begin
          if (tgt.tgt_valid && ready_q) begin
            exp_q      <= tgt.tgt_bit;
            {j_q, k_q} <= exc;
            ready_q    <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= StDrive;
          end
        end
        StDrive: state_q <= StCheck;
        StCheck: begin
          // On mismatch q is the complement of the target; resync to it.
          if (mismatch) track_q <= ~exp_q;
          else          track_q <= exp_q;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          k_q     <= 1'b1;
          ready_q <= 1'b0;
          busy_q  <= 1'b1;
          state_q <= StInit0;
        end
      endcase
    end
  end

  assign tgt.tgt_ready = ready_q;
  assign jk_j          = j_q;
  assign jk_k          = k_q;
  assign init_done     = init_done_q;
  assign busy          = busy_q;
  assign err_flag      = err_q;
  assign mism_cnt      = cnt_q;

endmodule

// File: tb/tb_jk_stim_driver.sv
// Directed bench: three drivers (fill 0, fill 1, 2-bit counter) each driving a JK flop model.
module tb_jk_stim_driver;

  logic clk = 1'b0;
  logic rst_n, tgt_valid, tgt_bit, clr_err, stuck0, stuck2;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  jk_stim_driver_if if0 ();
  jk_stim_driver_if if1 ();
  jk_stim_driver_if if2 ();

  assign if0.tgt_valid = tgt_valid;
  assign if0.tgt_bit   = tgt_bit;
  assign if1.tgt_valid = tgt_valid;
  assign if1.tgt_bit   = tgt_bit;
  assign if2.tgt_valid = tgt_valid;
  assign if2.tgt_bit   = tgt_bit;

  logic       j0, k0, q0, ff0, id0, b0, e0;
  logic       j1, k1, q1, ff1, id1, b1, e1;
  logic       j2, k2, q2, ff2, id2, b2, e2;
  logic [7:0] m0, m1;
  logic [1:0] m2;

  function automatic logic jk_next(input logic q, input logic j, input logic k);
    case ({j, k})
      2'b00:   return q;
      2'b01:   return 1'b0;
      2'b10:   return 1'b1;
      default: return ~q;
    endcase
  endfunction

  always @(posedge clk) ff0 <= jk_next(ff0, j0, k0);
  always @(posedge clk) ff1 <= jk_next(ff1, j1, k1);
  always @(posedge clk) ff2 <= jk_next(ff2, j2, k2);

  assign q0 = stuck0 ? 1'b0 : ff0;
  assign q1 = ff1;
  assign q2 = stuck2 ? 1'b0 : ff2;

  jk_stim_driver #(.CNT_W(8), .DC_FILL(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .tgt(if0), .clr_err(clr_err), .jk_q(q0), .jk_j(j0), .jk_k(k0),
    .init_done(id0), .busy(b0), .err_flag(e0), .mism_cnt(m0)
  );
  jk_stim_driver #(.CNT_W(8), .DC_FILL(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .tgt(if1), .clr_err(clr_err), .jk_q(q1), .jk_j(j1), .jk_k(k1),
    .init_done(id1), .busy(b1), .err_flag(e1), .mism_cnt(m1)
  );
  jk_stim_driver #(.CNT_W(2), .DC_FILL(1'b0)) dut2 (
    .clk(clk), .rst_n(rst_n), .tgt(if2), .clr_err(clr_err), .jk_q(q2), .jk_j(j2), .jk_k(k2),
    .init_done(id2), .busy(b2), .err_flag(e2), .mism_cnt(m2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One target through accept/DRIVE/CHECK; x0/x1 are expected {j,k} of dut0(=dut2)/dut1.
  task automatic send(input logic b, input logic [1:0] x0, input logic [1:0] x1,
                      input bit chk_q0, input bit chk_q1, input bit clr_in_check);
    int w = 0;
    while (!if0.tgt_ready && w < 8) begin
      tick();
      w++;
    end
    chk("ready_idle", if0.tgt_ready, 1'b1);
    tgt_valid = 1'b1;
    tgt_bit   = b;
    tick();
    tgt_valid = 1'b0;
    tgt_bit   = ~b;
    chk("drive_jk0", {j0, k0}, x0);
    chk("drive_jk1", {j1, k1}, x1);
    chk("drive_jk2", {j2, k2}, x0);
    chk("drive_rdy", if0.tgt_ready, 1'b0);
    tick();
    if (clr_in_check) clr_err = 1'b1;
    if (chk_q0) chk("check_q0", q0, b);
    if (chk_q1) chk("check_q1", q1, b);
    chk("check_jk0", {j0, k0}, 2'b00);
    chk("check_rdy", if1.tgt_ready, 1'b0);
    tick();
    clr_err = 1'b0;
  endtask

  initial begin
    int acc;
    rst_n = 1'b0; tgt_valid = 1'b0; tgt_bit = 1'b0; clr_err = 1'b0;
    stuck0 = 1'b0; stuck2 = 1'b0;
    tick();
    tick();
    chk("rst_jk", {j0, k0}, 2'b01);
    chk("rst_rdy", if0.tgt_ready, 1'b0);
    chk("rst_busy", b0, 1'b1);
    chk("rst_init", id0, 1'b0);
    chk("rst_cnt", m0, 8'd0);
    chk("rst_err", e0, 1'b0);
    rst_n = 1'b1;
    chk("init0_jk", {j1, k1}, 2'b01);
    tick();
    chk("initchk_jk", {j0, k0}, 2'b00);
    chk("initchk_done", id0, 1'b0);
    tick();
    chk("init_done0", id0, 1'b1);
    chk("init_done2", id2, 1'b1);
    chk("init_busy", b0, 1'b0);
    chk("init_cnt", m0, 8'd0);

    // Stream 1,1,0,0,1,0: fill 0 -> 10,00,01,00,10,01; fill 1 -> 11,10,11,01,11,11.
    send(1'b1, 2'b10, 2'b11, 1, 1, 0);
    send(1'b1, 2'b00, 2'b10, 1, 1, 0);
    send(1'b0, 2'b01, 2'b11, 1, 1, 0);
    send(1'b0, 2'b00, 2'b01, 1, 1, 0);
    send(1'b1, 2'b10, 2'b11, 1, 1, 0);
    send(1'b0, 2'b01, 2'b11, 1, 1, 0);
    chk("stream_cnt0", m0, 8'd0);
    chk("stream_cnt1", m1, 8'd0);
    chk("stream_err0", e0, 1'b0);

    // q stuck at 0 on dut0/dut2: every 1 mismatches, track resyncs to 0 so j=1 each time.
    stuck0 = 1'b1;
    stuck2 = 1'b1;
    send(1'b1, 2'b10, 2'b11, 0, 1, 0);
    send(1'b1, 2'b10, 2'b10, 0, 1, 0);
    send(1'b1, 2'b10, 2'b10, 0, 1, 0);
    chk("stuck_cnt0", m0, 8'd3);
    chk("stuck_err0", e0, 1'b1);
    chk("stuck_cnt2", m2, 2'd3);
    chk("stuck_cnt1", m1, 8'd0);
    send(1'b1, 2'b10, 2'b10, 0, 1, 0);
    send(1'b1, 2'b10, 2'b10, 0, 1, 0);
    chk("sat_cnt0", m0, 8'd5);
    chk("sat_cnt2", m2, 2'd3);
    send(1'b1, 2'b10, 2'b10, 0, 1, 1);
    chk("clr_mis_cnt0", m0, 8'd1);
    chk("clr_mis_cnt2", m2, 2'd1);
    chk("clr_mis_err2", e2, 1'b1);
    chk("clr_cnt1", m1, 8'd0);
    chk("clr_err1", e1, 1'b0);

    // Reset asserted mid-DRIVE takes effect without waiting for a clock edge.
    stuck0 = 1'b0;
    stuck2 = 1'b0;
    tgt_valid = 1'b1;
    tgt_bit   = 1'b1;
    tick();
    chk("pre_rst_jk", {j0, k0}, 2'b10);
    #3 rst_n = 1'b0;
    tgt_valid = 1'b0;
    #1;
    chk("mid_rst_jk", {j0, k0}, 2'b01);
    chk("mid_rst_rdy", if0.tgt_ready, 1'b0);
    chk("mid_rst_busy", b0, 1'b1);
    chk("mid_rst_init", id0, 1'b0);
    chk("mid_rst_cnt0", m0, 8'd0);
    chk("mid_rst_err2", e2, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    tick();
    chk("reinit_done", id0, 1'b1);

    // Valid held high: exactly one accept every three cycles.
    acc = 0;
    tgt_valid = 1'b1;
    tgt_bit   = 1'b1;
    for (int i = 0; i < 9; i++) begin
      chk("hold_rdy", if0.tgt_ready, (i % 3 == 0) ? 1'b1 : 1'b0);
      if (if0.tgt_ready && tgt_valid) acc++;
      tick();
    end
    tgt_valid = 1'b0;
    chk("hold_accepts", acc, 3);
    chk("hold_q0", q0, 1'b1);
    chk("hold_cnt0", m0, 8'd0);
    send(1'b0, 2'b01, 2'b11, 1, 1, 0);
    chk("final_cnt0", m0, 8'd0);
    chk("final_err1", e1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
